// File: rtl/delay_mem_pkg.sv
// Shared definitions for the delay-line memory scheduler: FSM state encoding
// and a constant-evaluable ceiling log2.
package delay_mem_pkg;

  typedef enum logic [2:0] {
    ST_CLEAN   = 3'd0,
    ST_IDLE    = 3'd1,
    ST_WRITE   = 3'd2,
    ST_READ    = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/delay_mem_scheduler.sv
// Time-multiplexes one single-port, 1-cycle-latency sample RAM between NCH delay
// lines: per lrclk frame, one write slot and one offset-read slot per channel.
module delay_mem_scheduler
  import delay_mem_pkg::*;
#(
  parameter int BITSIZE = 16,
  parameter int NCH     = 2,
  parameter int ADDRLEN = 14
) (
  input  logic                       bclk,
  input  logic                       rst_n,
  input  logic                       lrclk,
  input  logic [NCH-1:0]             enable,
  input  logic [NCH*(ADDRLEN-clog2(NCH))-1:0] offset,
  input  logic [NCH*BITSIZE-1:0]     ch_in,
  output logic [NCH*BITSIZE-1:0]     ch_out,
  output logic [NCH-1:0]             ch_valid,
  output logic [ADDRLEN-1:0]         mem_addr,
  output logic [BITSIZE-1:0]         mem_wdata,
  output logic                       mem_wren,
  input  logic [BITSIZE-1:0]         mem_rdata,
  output logic                       busy,
  output logic                       overrun
);

  localparam int CHB   = clog2(NCH);
  localparam int RBITS = ADDRLEN - CHB;
  localparam int CHW   = (CHB > 0) ? CHB : 1;

  state_t                    state, state_nxt;
  logic [ADDRLEN-1:0]        clean_addr;
  logic [RBITS-1:0]          wr_ptr;
  logic [CHW-1:0]            ch, ch_nxt, wch;
  logic                      lrclk_d;
  logic                      frame_start;
  logic                      last_ch;
  logic [ADDRLEN-1:0]        mem_addr_nxt;
  logic [BITSIZE-1:0]        mem_wdata_nxt;
  logic                      mem_wren_nxt;
  logic signed [BITSIZE-1:0] wr_word;

  logic signed [BITSIZE-1:0] in_s     [NCH];
  logic        [RBITS-1:0]   off_s    [NCH];
  logic signed [BITSIZE-1:0] ch_out_r [NCH];

  for (genvar k = 0; k < NCH; k++) begin : g_slice
    assign in_s[k] = ch_in[k*BITSIZE +: BITSIZE];
    assign off_s[k] = offset[k*RBITS +: RBITS];
    assign ch_out[k*BITSIZE +: BITSIZE] = ch_out_r[k];
  end

  // Channel index occupies the top address bits; region arithmetic never carries into it.
  function automatic logic [ADDRLEN-1:0] chan_addr(input logic [CHW-1:0] c,
                                                    input logic [RBITS-1:0] r);
    return (ADDRLEN'(c) << RBITS) | ADDRLEN'(r);
  endfunction

  assign frame_start = lrclk & ~lrclk_d;
  assign last_ch     = (ch == CHW'(NCH - 1));
  assign busy        = (state != ST_IDLE);

  // Channel whose write slot is being set up for the next cycle.
  assign wch     = (state == ST_CAPTURE && !last_ch) ? ch + CHW'(1) : '0;
  assign wr_word = enable[wch] ? in_s[wch] : '0;

  always_comb begin
    state_nxt     = state;
    ch_nxt        = ch;
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = '0;
    mem_wren_nxt  = 1'b0;
    unique case (state)
      ST_CLEAN: begin
        mem_addr_nxt = clean_addr;
        mem_wren_nxt = 1'b1;
        if (clean_addr == '1) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (frame_start) begin
          state_nxt     = ST_WRITE;
          ch_nxt        = '0;
          mem_addr_nxt  = chan_addr('0, wr_ptr);
          mem_wdata_nxt = wr_word;
          mem_wren_nxt  = 1'b1;
        end
      end
      ST_WRITE: begin
        state_nxt    = ST_READ;
        mem_addr_nxt = chan_addr(ch, wr_ptr + off_s[ch]);
      end
      ST_READ: begin
        state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (last_ch) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt     = ST_WRITE;
          ch_nxt        = wch;
          mem_addr_nxt  = chan_addr(wch, wr_ptr);
          mem_wdata_nxt = wr_word;
          mem_wren_nxt  = 1'b1;
        end
      end
      default: state_nxt = ST_CLEAN;
    endcase
  end

  // Memory port and control registers: the RAM sees values stable for a full cycle.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_CLEAN;
      clean_addr <= '0;
      wr_ptr     <= '0;
      ch         <= '0;
      lrclk_d    <= 1'b0;
      overrun    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wren   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ch        <= ch_nxt;
      lrclk_d   <= lrclk;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      mem_wren  <= mem_wren_nxt;
      if (state == ST_CLEAN) clean_addr <= clean_addr + ADDRLEN'(1);
      if (state == ST_CAPTURE && last_ch) wr_ptr <= wr_ptr + RBITS'(1);
      if (frame_start && state != ST_IDLE && state != ST_CLEAN) overrun <= 1'b1;
    end
  end

  // Output capture: read data returns in the slot after the read address.
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      ch_valid <= '0;
      for (int k = 0; k < NCH; k++) ch_out_r[k] <= '0;
    end else begin
      ch_valid <= '0;
      if (state == ST_CAPTURE) begin
        ch_valid[ch] <= 1'b1;
        ch_out_r[ch] <= enable[ch] ? mem_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_delay_mem_scheduler.sv
// Directed bench for delay_mem_scheduler with a behavioural single-port RAM,
// a per-channel delay-line model and an output scoreboard.
module tb_delay_mem_scheduler;

  localparam int BITSIZE = 16;
  localparam int NCH     = 2;
  localparam int ADDRLEN = 14;
  localparam int RBITS   = 13;
  localparam int DEPTH   = 1 << ADDRLEN;
  localparam int RDEPTH  = 1 << RBITS;

  logic                   bclk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   lrclk = 1'b0;
  logic [NCH-1:0]         enable = '0;
  logic [NCH*RBITS-1:0]   offset = '0;
  logic [NCH*BITSIZE-1:0] ch_in = '0;
  logic [NCH*BITSIZE-1:0] ch_out;
  logic [NCH-1:0]         ch_valid;
  logic [ADDRLEN-1:0]     mem_addr;
  logic [BITSIZE-1:0]     mem_wdata;
  logic                   mem_wren;
  logic [BITSIZE-1:0]     mem_rdata;
  logic                   busy;
  logic                   overrun;

  delay_mem_scheduler #(.BITSIZE(BITSIZE), .NCH(NCH), .ADDRLEN(ADDRLEN)) dut (
    .bclk(bclk), .rst_n(rst_n), .lrclk(lrclk), .enable(enable), .offset(offset),
    .ch_in(ch_in), .ch_out(ch_out), .ch_valid(ch_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wren(mem_wren), .mem_rdata(mem_rdata),
    .busy(busy), .overrun(overrun)
  );

  always #5 bclk = ~bclk;

  // Single-port memory wrapper model: one-cycle read latency, read-before-write.
  logic [BITSIZE-1:0] ram [DEPTH];
  always @(posedge bclk) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct {
    int          ch;
    logic [15:0] val;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mdl [NCH][RDEPTH];
  int          p = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input int k);
    exp_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(k + 1), 32'd0);
    end else begin
      e = sb.pop_front();
      chk("sb_ch", 32'(k), 32'(e.ch));
      chk("sb_out", {16'h0, ch_out[k*BITSIZE +: BITSIZE]}, {16'h0, e.val});
    end
  endtask

  // One frame: called at a negedge, starts lrclk high, checks 7 cycles, ends at a negedge.
  task automatic frame(input logic [1:0] en, input logic [15:0] in0, input logic [15:0] in1,
                       input logic [12:0] off0, input logic [12:0] off1, input bit glitch);
    logic [15:0] w0, w1;
    logic [12:0] pp, r0, r1;
    exp_t        e;
    pp = p[12:0];
    r0 = pp + off0;
    r1 = pp + off1;
    w0 = en[0] ? in0 : 16'h0;
    w1 = en[1] ? in1 : 16'h0;
    enable = en;
    ch_in  = {in1, in0};
    offset = {off1, off0};
    lrclk  = 1'b1;
    mdl[0][pp] = w0;
    e.ch = 0; e.val = en[0] ? mdl[0][r0] : 16'h0; sb.push_back(e);
    mdl[1][pp] = w1;
    e.ch = 1; e.val = en[1] ? mdl[1][r1] : 16'h0; sb.push_back(e);
    for (int i = 1; i <= 7; i++) begin
      @(negedge bclk);
      if (i == 1) lrclk = 1'b0;
      if (glitch && i == 2) lrclk = 1'b1;
      if (glitch && i == 3) lrclk = 1'b0;
      for (int k = 0; k < NCH; k++) if (ch_valid[k]) pop_check(k);
      case (i)
        1: begin
          chk("wr0_addr", mem_addr, {1'b0, pp});
          chk("wr0_wren", mem_wren, 1);
          chk("wr0_data", mem_wdata, w0);
          chk("wr0_busy", busy, 1);
        end
        2: begin
          chk("rd0_addr", mem_addr, {1'b0, r0});
          chk("rd0_wren", mem_wren, 0);
        end
        4: begin
          chk("vld0", ch_valid, 2'b01);
          chk("wr1_addr", mem_addr, {1'b1, pp});
          chk("wr1_wren", mem_wren, 1);
          chk("wr1_data", mem_wdata, w1);
        end
        5: begin
          chk("rd1_addr", mem_addr, {1'b1, r1});
          chk("rd1_wren", mem_wren, 0);
        end
        7: begin
          chk("vld1", ch_valid, 2'b10);
          chk("idle_busy", busy, 0);
          chk("idle_wren", mem_wren, 0);
        end
        default: chk("no_vld", ch_valid, 0);
      endcase
    end
    p = (p + 1) % RDEPTH;
  endtask

  initial begin
    int busy_cnt, bad, i;
    bit done;
    logic [12:0] pp;

    for (int c = 0; c < NCH; c++)
      for (int a = 0; a < RDEPTH; a++) mdl[c][a] = 16'h0;

    // Reset state
    repeat (3) @(posedge bclk);
    #1;
    chk("rst_wren", mem_wren, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_busy", busy, 1);
    chk("rst_out", ch_out, 0);
    chk("rst_vld", ch_valid, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;

    // Power-up zero-fill with lrclk running
    busy_cnt = 0; bad = 0; i = 0; done = 0;
    while (!done && i < 20000) begin
      @(negedge bclk);
      lrclk = ((i / 32) % 2) == 1;
      if (busy) busy_cnt++;
      if (i >= 1 && i <= DEPTH)
        if (mem_wren !== 1'b1 || mem_addr !== 14'(i - 1) || mem_wdata !== 16'h0 ||
            ch_out !== '0 || overrun !== 1'b0) bad++;
      if (busy !== 1'b1) done = 1;
      i++;
    end
    chk("clean_cycles", busy_cnt, DEPTH);
    chk("clean_words", bad, 0);
    lrclk = 1'b0;
    @(negedge bclk);
    chk("post_clean_wren", mem_wren, 0);
    chk("post_clean_ovr", overrun, 0);
    @(negedge bclk);

    // Same-frame readback, then one-frame delay on channel 1
    frame(2'b11, 16'h1234, 16'h0000, 13'd0, 13'd0, 0);
    frame(2'b11, 16'h0042, 16'd100, 13'd0, 13'd8191, 0);
    frame(2'b11, 16'h0043, 16'd200, 13'd0, 13'd8191, 0);

    // Disabled channel drains
    pp = p[12:0];
    frame(2'b10, 16'h7FFF, 16'h0055, 13'd0, 13'd8191, 0);
    chk("drain_word", ram[{1'b0, pp}], 16'h0);
    chk("ch1_word", ram[{1'b1, pp}], 16'h0055);

    // Full pointer wrap with random samples and channel-0 offsets
    for (int f = 0; f < RDEPTH; f++)
      frame(2'b11, 16'($urandom), 16'($urandom), 13'($urandom), 13'd8191, 0);
    chk("wrap_ptr", p, 4);
    chk("wrap_ovr", overrun, 0);

    // Second lrclk edge mid-frame
    frame(2'b11, 16'h0001, 16'h0002, 13'd5, 13'd8191, 1);
    chk("overrun_set", overrun, 1);
    frame(2'b01, 16'h0003, 16'h0004, 13'd8191, 13'd1, 0);
    chk("overrun_sticky", overrun, 1);

    // Asynchronous reset during a write slot
    lrclk = 1'b1;
    @(negedge bclk);
    lrclk = 1'b0;
    chk("pre_rst_wren", mem_wren, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_wren", mem_wren, 0);
    chk("async_addr", mem_addr, 0);
    chk("async_ovr", overrun, 0);
    chk("async_out", ch_out, 0);
    chk("async_busy", busy, 1);
    @(negedge bclk);
    rst_n = 1'b1;
    @(negedge bclk);
    chk("reclean_wren", mem_wren, 1);
    chk("reclean_addr", mem_addr, 0);
    chk("reclean_data", mem_wdata, 0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/delay_mem_scheduler.md
Name: delay_mem_scheduler

Overview:
- Time-multiplexes one single-port, 1-cycle-latency audio sample RAM between NCH delay-line channels (echo, delay, chorus taps).
- Once per lrclk frame it runs one write slot and one offset-read slot per channel, in channel order.
- Owns the shared write pointer, the power-up zero-fill ("cleaning") and per-channel output holding.
- Sits between the effect datapaths and the memory wrapper on the bclk domain.

Parameters:
BITSIZE, 16, sample width (signed)
NCH, 2, number of channels sharing the RAM; must satisfy 3*NCH+2 <= 64
ADDRLEN, 14, total RAM address width; each channel gets a region of 2**(ADDRLEN-CHB) words, CHB = clog2(NCH) (localparam RBITS = ADDRLEN-CHB)

Ports:
bclk  in  1  bit clock, 64x lrclk, sole clock
rst_n  in  1  asynchronous active-low reset
lrclk  in  1  frame clock; the rising edge starts a frame
enable  in  NCH  per-channel enable
offset  in  NCH*RBITS  per-channel read offset (delay = 2**RBITS - offset frames; offset 0 = same-frame readback)
ch_in  in  NCH*BITSIZE  per-channel sample to store, already mixed by the effect
ch_out  out  NCH*BITSIZE  per-channel delayed sample, registered, held between updates
ch_valid  out  NCH  one-cycle pulse when the matching ch_out slice updates
mem_addr  out  ADDRLEN  RAM address, {ch, region_addr}
mem_wdata  out  BITSIZE  RAM write data
mem_wren  out  1  RAM write enable
mem_rdata  in  BITSIZE  RAM read data, valid 1 cycle after address
busy  out  1  high outside IDLE (includes CLEAN)
overrun  out  1  sticky: an lrclk edge arrived while a frame was in progress

Behaviour:
- Reset (async, any state): state=CLEAN, clean_addr=0, wr_ptr=0, ch=0, all ch_out=0, ch_valid=0, mem_wren=0, mem_addr=0, mem_wdata=0, overrun=0, lrclk_d=0. On release, the FSM starts CLEAN on the next bclk edge.
- Edge detect: lrclk_d registered each cycle; frame_start = lrclk & ~lrclk_d.
- CLEAN: each cycle mem_addr=clean_addr, mem_wdata=0, mem_wren=1, clean_addr++. After writing address 2**ADDRLEN-1, go to IDLE (2**ADDRLEN cycles total). frame_start is ignored and does not set overrun. ch_out stays 0.
- IDLE: mem_wren=0. On frame_start, set ch=0 and go to WRITE.
- WRITE: mem_addr={ch, wr_ptr}; mem_wren=1. mem_wdata=ch_in[ch] if enable[ch], else 0, so a disabled line drains. Go to READ.
- READ: mem_addr={ch, (wr_ptr+offset[ch]) mod 2**RBITS}; mem_wren=0. Go to CAPTURE.
- CAPTURE: ch_out[ch] <= enable[ch] ? mem_rdata : 0; ch_valid[ch]=1 for this cycle.
  - If ch==NCH-1: wr_ptr <= wr_ptr+1 (wraps at 2**RBITS) and go to IDLE.
  - Else: ch++ and go to WRITE.
- Frame latency: channel k output updates 3k+3 cycles after the frame_start cycle. Whole frame is 3*NCH cycles, then IDLE.
- frame_start outside IDLE and CLEAN: ignored (frame not restarted) and overrun<=1.
- ch_in, enable and offset are sampled in the cycle that uses them; there is no other latching.
- Addition is unsigned modulo 2**RBITS; region bits never carry into the channel bits.
- Non-power-of-2 NCH: the unused top regions are cleaned but never accessed.
- mem_* outputs are registered from state, so the RAM sees stable address and data for the whole cycle.

Decomposition:
- Shared package delay_mem_pkg: state encoding (CLEAN, IDLE, WRITE, READ, CAPTURE) and a clog2 function.
- No sub-module inside the block: the FSM, pointer and output registers form one unit.
- The RAM stays outside as the existing single-port memory wrapper. The bench instantiates that wrapper as the behavioural model.

Test Plan (all with NCH=2, ADDRLEN=14, RBITS=13):
1. Reset release with lrclk toggling -> busy=1 for exactly 16384 cycles; mem_wren=1 with wdata=0 over addresses 0..16383; ch_out=0; overrun stays 0.
2. After clean, enable=2'b11, offset0=0, ch_in0=16'h1234 -> ch_valid[0] pulses 3 cycles after frame_start with ch_out0=16'h1234; ch_valid[1] pulses 3 cycles later.
3. offset1=8191 (delay 1 frame), ch_in1=100 then 200 on consecutive frames -> ch_out1 = 0 in the frame where 100 is written, then 100 in the next frame.
4. Run 8192 frames -> wr_ptr wraps to 0; channel 1 addresses stay within 8192..16383 and channel 0 within 0..8191.
5. enable[0]=0 with ch_in0=16'h7FFF -> written word is 0 and ch_out0=0; channel 1 is unaffected.
6. Second lrclk rising edge 2 cycles after frame_start -> overrun=1 and stays set, and the frame completes normally. Then assert rst_n=0 during WRITE -> mem_wren drops immediately and the FSM re-enters CLEAN.
